pwl_activation_unit: RTL and testbench

//  Applies a programmable piecewise-linear activation y = a*x + b to a vector of
//  NU_COUNT Q4.12 neuron outputs. One shared 64-segment coefficient LUT serves all lanes.

---
 rtl/pwl_activation_unit.sv | 145 ++++++++++++++
 tb/tb_pwl_activation_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwl_activation_unit.sv
// rtl/pwl_activation_unit.sv - 3-stage piecewise-linear activation y = a*x + b over LANES Q4.12 lanes
// One shared 64-segment coefficient LUT; all stages advance together when the output is free.
module pwl_activation_unit #(
    parameter int LANES     = 4,
    parameter int Q_INT     = 4,
    parameter int Q_FRAC    = 12,
    parameter int LUT_DEPTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*(Q_INT+Q_FRAC)-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*(Q_INT+Q_FRAC)-1:0] out_data,
    input  logic                       lut_we,
    input  logic [LUT_DEPTH-1:0]       lut_addr,
    input  logic [Q_INT+Q_FRAC-1:0]    lut_a,
    input  logic [Q_INT+Q_FRAC-1:0]    lut_b
);
    localparam int W    = Q_INT + Q_FRAC;
    localparam int PW   = 2 * W;
    localparam int SW   = PW - Q_FRAC + 1;
    localparam int SEGS = 1 << LUT_DEPTH;
    localparam logic [W-1:0] ONE = W'(1) << Q_FRAC;

    logic [W-1:0] lut_a_q [SEGS];
    logic [W-1:0] lut_a_d [SEGS];
    logic [W-1:0] lut_b_q [SEGS];
    logic [W-1:0] lut_b_d [SEGS];

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [W-1:0]         x1_q [LANES];
    logic [W-1:0]         x1_d [LANES];
    logic [W-1:0]         a1_q [LANES];
    logic [W-1:0]         a1_d [LANES];
    logic [W-1:0]         b1_q [LANES];
    logic [W-1:0]         b1_d [LANES];
    logic signed [PW-1:0] p2_q [LANES];
    logic signed [PW-1:0] p2_d [LANES];
    logic [W-1:0]         b2_q [LANES];
    logic [W-1:0]         b2_d [LANES];
    logic [W-1:0]         y_q  [LANES];
    logic [W-1:0]         y_d  [LANES];

    logic [LUT_DEPTH-1:0] idx   [LANES];
    logic [W-1:0]         x_in  [LANES];
    logic signed [PW-1:0] prod  [LANES];
    logic signed [PW-1:0] rnd   [LANES];
    logic signed [SW-1:0] sum   [LANES];
    logic [W-1:0]         sat   [LANES];
    logic                 adv;

    // Per-lane arithmetic; segment index flips the sign bit so idx 0 is the most negative segment.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x_in[i] = in_data[W*i +: W];
            idx[i]  = {~x_in[i][W-1], x_in[i][W-2 -: LUT_DEPTH-1]};
            prod[i] = {{W{x1_q[i][W-1]}}, x1_q[i]} * {{W{a1_q[i][W-1]}}, a1_q[i]};
            rnd[i]  = (p2_q[i] + (PW'(1) <<< (Q_FRAC - 1))) >>> Q_FRAC;
            sum[i]  = SW'(rnd[i]) + {{(SW-W){b2_q[i][W-1]}}, b2_q[i]};
            if (sum[i] > $signed(SW'((1 << (W-1)) - 1)))
                sat[i] = {1'b0, {(W-1){1'b1}}};
            else if (sum[i] < -$signed(SW'(1 << (W-1))))
                sat[i] = {1'b1, {(W-1){1'b0}}};
            else
                sat[i] = sum[i][W-1:0];
        end
    end

    always_comb begin
        adv     = ~v3_q | out_ready;
        lut_a_d = lut_a_q;
        lut_b_d = lut_b_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        x1_d    = x1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        p2_d    = p2_q;
        b2_d    = b2_q;
        y_d     = y_q;
        if (lut_we) begin
            lut_a_d[lut_addr] = lut_a;
            lut_b_d[lut_addr] = lut_b;
        end
        if (adv) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            for (int i = 0; i < LANES; i++) begin
                x1_d[i] = x_in[i];
                a1_d[i] = lut_a_q[idx[i]];
                b1_d[i] = lut_b_q[idx[i]];
                p2_d[i] = prod[i];
                b2_d[i] = b1_q[i];
                y_d[i]  = sat[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SEGS; s++) begin
                lut_a_q[s] <= ONE;
                lut_b_q[s] <= '0;
            end
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                x1_q[i] <= '0;
                a1_q[i] <= '0;
                b1_q[i] <= '0;
                p2_q[i] <= '0;
                b2_q[i] <= '0;
                y_q[i]  <= '0;
            end
        end else begin
            lut_a_q <= lut_a_d;
            lut_b_q <= lut_b_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            x1_q    <= x1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            p2_q    <= p2_d;
            b2_q    <= b2_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++)
            out_data[W*i +: W] = y_q[i];
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;

endmodule

// File: tb/tb_pwl_activation_unit.sv
// tb/tb_pwl_activation_unit.sv - directed self-checking bench for pwl_activation_unit
module tb_pwl_activation_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        lut_we;
    logic [5:0]  lut_addr;
    logic [15:0] lut_a;
    logic [15:0] lut_b;

    int n_vec = 0;
    int n_err = 0;

    pwl_activation_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_a(lut_a), .lut_b(lut_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic lut_fill(input logic [15:0] a, input logic [15:0] b);
        for (int s = 0; s < 64; s++) begin
            @(negedge clk);
            lut_we = 1'b1; lut_addr = 6'(s); lut_a = a; lut_b = b;
        end
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    task automatic lut_write1(input logic [5:0] addr, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        lut_we = 1'b1; lut_addr = addr; lut_a = a; lut_b = b;
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    task automatic send_one(input string tag, input logic [15:0] x, input logic [15:0] y);
        int cnt;
        @(negedge clk);
        in_valid = 1'b1; in_data = rep4(x); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, 64'(cnt), 64'd3);
        check(tag, out_data, rep4(y));
    endtask

    logic [63:0] vecs [10];
    logic [15:0] ready_pat = 16'b1011_0010_0110_1001;
    logic [63:0] held_data;
    logic        held;
    int          sent, rcv, hits, cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        lut_we = 1'b0; lut_addr = '0; lut_a = '0; lut_b = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", out_data, 64'd0);
        rst_n = 1'b1;

        // 1: identity LUT after reset
        send_one("t1_identity", 16'h1800, 16'h1800);

        // 2: a=2.0, b=-1.0
        lut_fill(16'h2000, 16'hF000);
        send_one("t2_pos", 16'h0800, 16'h0000);
        send_one("t2_neg", 16'hF800, 16'hE000);

        // 3: saturation rails
        lut_fill(16'h7FFF, 16'h0000);
        send_one("t3_sat_hi", 16'h7FFF, 16'h7FFF);
        send_one("t3_sat_lo", 16'h8000, 16'h8000);

        // 4: smallest slope, rounding half up
        lut_write1(6'd34, 16'h0001, 16'h0000);
        send_one("t4_round", 16'h0800, 16'h0001);

        // 5: streaming with back-pressure on identity coefficients
        lut_fill(16'h1000, 16'h0000);
        for (int k = 0; k < 10; k++)
            for (int l = 0; l < 4; l++)
                vecs[k][16*l +: 16] = 16'(k * 801 + l * 4369 + 7);
        sent = 0; rcv = 0; held = 1'b0; held_data = '0;
        for (int c = 0; c < 200 && rcv < 10; c++) begin
            @(negedge clk);
            if (held) begin
                check("t5_hold_valid", 64'(out_valid), 64'd1);
                check("t5_hold_data", out_data, held_data);
            end
            out_ready = ready_pat[c % 16];
            in_valid  = (sent < 10);
            in_data   = (sent < 10) ? vecs[sent] : 64'd0;
            #1;
            if (out_valid && out_ready) begin
                check("t5_order", out_data, vecs[rcv]);
                rcv++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("t5_sent", 64'(sent), 64'd10);
        check("t5_received", 64'(rcv), 64'd10);
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("t5_no_dup", 64'(hits), 64'd0);

        // 6: write to idx 32 in the same cycle a vector looks it up
        @(negedge clk);
        lut_we = 1'b1; lut_addr = 6'd32; lut_a = 16'h2000; lut_b = 16'h1000;
        in_valid = 1'b1; in_data = 64'd0; out_ready = 1'b1;
        @(negedge clk);
        lut_we = 1'b0; in_data = 64'd0;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("t6_old_coef", out_data, 64'd0);
        @(negedge clk);
        check("t6_new_valid", 64'(out_valid), 64'd1);
        check("t6_new_coef", out_data, rep4(16'h1000));

        // reset with three vectors in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = rep4(16'h1800); out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("t6_inflight", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_data", out_data, 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("t6_no_stale", 64'(hits), 64'd0);
        send_one("t6_ident_idx32", 16'h0000, 16'h0000);
        send_one("t6_ident_idx38", 16'h1800, 16'h1800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
